generador_sync_vga: RTL and testbench
=====================================

GENERADOR_SYNC_VGA -- requirements
Module: generador_sync_vga

Interface
REQ-001 The block SHALL have one clock and one reset; the reset is asynchronous and active-high.
REQ-002 Parameter DIV_PIXEL, default 4, SHALL set the number of reloj cycles per pixel.
REQ-003 Parameters H_VIS/H_FP/H_SYNC/H_BP, defaults 640/16/96/48, SHALL set the horizontal timing in pixels (total 800).
REQ-004 Parameters V_VIS/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, SHALL set the vertical timing in lines (total 525).
REQ-005 Port reloj, input, 1 bit: system clock, 100 MHz nominal.
REQ-006 Port resetM, input, 1 bit: asynchronous active-high reset.
REQ-007 Port Qh, output, 10 bits: horizontal pixel counter, feeds Posicion_Mosaicos.Qh.
REQ-008 Port Qv, output, 10 bits: vertical line counter, feeds Posicion_Mosaicos.Qv.
REQ-009 Port pixel_tick, output, 1 bit: single-cycle pixel strobe.
REQ-010 Port hsync, output, 1 bit: horizontal sync, active low.
REQ-011 Port vsync, output, 1 bit: vertical sync, active low.
REQ-012 Port video_on, output, 1 bit: high inside the visible area.
REQ-013 Port fin_cuadro, output, 1 bit: end-of-frame pulse; present only with GENSYNC_FRAME_TICK_EN.

Function
REQ-014 The 2-bit prescaler SHALL count 0..DIV_PIXEL-1 and wrap to 0.
REQ-015 pixel_tick SHALL be high exactly when the prescaler equals DIV_PIXEL-1, giving a pattern of 0,0,0,1.
REQ-016 Qh SHALL change only on a rising edge where pixel_tick=1, so each value holds for DIV_PIXEL cycles.
REQ-017 Qh SHALL count 0..799; at 799 with a tick, Qh SHALL go to 0 and Qv SHALL increment on the same edge.
REQ-018 Qv SHALL count 0..524; at Qh=799, Qv=524 with a tick, both counters SHALL go to 0 on the same edge.
REQ-019 hsync, vsync and video_on SHALL be registered, update on the same edge as Qh/Qv, and decode the new counter values (zero skew versus Qh/Qv).
REQ-020 hsync SHALL be 0 iff 656 <= Qh <= 751, otherwise 1.
REQ-021 vsync SHALL be 0 iff 490 <= Qv <= 491, otherwise 1.
REQ-022 video_on SHALL be 1 iff Qh < 640 and Qv < 480.
REQ-023 Counter values outside the legal range SHALL be unreachable; the wrap compares SHALL use equality with total-1.

Reset
REQ-024 While resetM=1, the block SHALL hold prescaler=0, Qh=0, Qv=0, pixel_tick=0, hsync=1, vsync=1, video_on=0 and fin_cuadro=0, independent of reloj.
REQ-025 Reset asserted mid-line or mid-frame SHALL force the reset values immediately, with no completion of the current pixel.
REQ-026 After release, the first tick SHALL occur in the 4th cycle, and Qh SHALL become 1 on the 4th rising edge.
REQ-027 video_on SHALL stay 0 until the first tick after release.

Configuration
REQ-028 When GENSYNC_FRAME_TICK_EN is defined, fin_cuadro SHALL pulse high for one reloj cycle on the edge where (Qh, Qv) wraps from (799, 524) to (0, 0).
REQ-029 When GENSYNC_FRAME_TICK_EN is undefined, the fin_cuadro port and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-030 Package vga_timing_pkg SHALL hold the timing defaults, the totals (800, 525), the sync start/end constants and the counter width (10).
REQ-031 Sub-module divisor_pixel (prescaler plus pixel_tick) SHALL be instantiated once; the counters and decode SHALL live in the top module.

Verification
REQ-032 Release resetM at t0 -> Qh=0 for 4 clocks, pixel_tick pattern 0,0,0,1, and Qh=1 after the 4th edge.
REQ-033 Run to Qh=799, Qv=10 -> on the next tick Qh=0 and Qv=11 on the same edge, with no intermediate value.
REQ-034 Run a full frame -> (799, 524) goes to (0, 0) after 1,680,000 clocks; fin_cuadro is high exactly 1 cycle (macro on) and the port is absent (macro off).
REQ-035 Over one line -> hsync is low for exactly 384 clocks starting at Qh=656; over one frame -> vsync is low for exactly 2 lines starting at Qv=490.
REQ-036 Over one frame -> video_on is high for 307,200 ticks (640x480) and never high when Qh >= 640 or Qv >= 480.
REQ-037 Assert resetM asynchronously at Qh=300, Qv=100, mid-prescaler -> all outputs reach reset values before the next edge, and restart follows REQ-026.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants shared by the sync generator and its prescaler.
package vga_timing_pkg;

    // Counter width for both Qh and Qv
    localparam int unsigned CNT_W = 10;

    // Prescaler width for the default divide-by-4 pixel clock
    localparam int unsigned PRESC_W = 2;

    // Default pixel clock divider (100 MHz -> 25 MHz)
    localparam int unsigned DIV_PIXEL_DEF = 4;

    // Horizontal timing in pixels
    localparam int unsigned H_VIS_DEF  = 640;
    localparam int unsigned H_FP_DEF   = 16;
    localparam int unsigned H_SYNC_DEF = 96;
    localparam int unsigned H_BP_DEF   = 48;
    localparam int unsigned H_TOTAL    = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    // Vertical timing in lines
    localparam int unsigned V_VIS_DEF  = 480;
    localparam int unsigned V_FP_DEF   = 10;
    localparam int unsigned V_SYNC_DEF = 2;
    localparam int unsigned V_BP_DEF   = 33;
    localparam int unsigned V_TOTAL    = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Sync pulse windows (inclusive)
    localparam int unsigned H_SYNC_START = H_VIS_DEF + H_FP_DEF;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
    localparam int unsigned V_SYNC_START = V_VIS_DEF + V_FP_DEF;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

endpackage

// File: rtl/divisor_pixel.sv
// Pixel prescaler: counts 0..DIV_PIXEL-1 and strobes pixel_tick on the last count.
module divisor_pixel
    import vga_timing_pkg::*;
#(
    parameter int unsigned DIV_PIXEL = DIV_PIXEL_DEF
) (
    input  logic reloj,
    input  logic resetM,
    output logic pixel_tick
);

    localparam int unsigned PW = (DIV_PIXEL > 1) ? $clog2(DIV_PIXEL) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV_PIXEL - 1);

    logic [PW-1:0] presc_q;

    // Prescaler register, wraps on equality with the last count
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            presc_q <= '0;
        end else if (presc_q == LAST) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // Strobe decodes the registered count, so it is low throughout reset
    always_comb begin
        pixel_tick = (presc_q == LAST);
    end

endmodule

// File: rtl/generador_sync_vga.sv
// VGA sync generator: pixel/line counters with registered, zero-skew sync decode.
// Optional end-of-frame pulse on fin_cuadro when GENSYNC_FRAME_TICK_EN is defined.
module generador_sync_vga
    import vga_timing_pkg::*;
#(
    parameter int unsigned DIV_PIXEL = DIV_PIXEL_DEF,
    parameter int unsigned H_VIS     = H_VIS_DEF,
    parameter int unsigned H_FP      = H_FP_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BP      = H_BP_DEF,
    parameter int unsigned V_VIS     = V_VIS_DEF,
    parameter int unsigned V_FP      = V_FP_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BP      = V_BP_DEF
) (
    input  logic             reloj,
    input  logic             resetM,
    output logic [CNT_W-1:0] Qh,
    output logic [CNT_W-1:0] Qv,
    output logic             pixel_tick,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on
`ifdef GENSYNC_FRAME_TICK_EN
    ,
    output logic             fin_cuadro
`endif
);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VIS + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0] qh_q, qh_d;
    logic [CNT_W-1:0] qv_q, qv_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic             tick;

    divisor_pixel #(
        .DIV_PIXEL (DIV_PIXEL)
    ) u_divisor_pixel (
        .reloj      (reloj),
        .resetM     (resetM),
        .pixel_tick (tick)
    );

    // Next counter values; sync/blank decode the *next* values so they land with the counters
    always_comb begin
        qh_d = qh_q;
        qv_d = qv_q;
        if (qh_q == H_LAST) begin
            qh_d = '0;
            if (qv_q == V_LAST) begin
                qv_d = '0;
            end else begin
                qv_d = qv_q + CNT_W'(1);
            end
        end else begin
            qh_d = qh_q + CNT_W'(1);
        end
        hsync_d    = !((qh_d >= HS_FIRST) && (qh_d <= HS_LAST));
        vsync_d    = !((qv_d >= VS_FIRST) && (qv_d <= VS_LAST));
        video_on_d = (qh_d < H_VIS_C) && (qv_d < V_VIS_C);
    end

    // Counters and decoded outputs advance only on pixel ticks
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            qh_q       <= '0;
            qv_q       <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b0;
        end else if (tick) begin
            qh_q       <= qh_d;
            qv_q       <= qv_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
        end
    end

`ifdef GENSYNC_FRAME_TICK_EN
    logic frame_wrap;
    logic fin_cuadro_q;

    // Wrap of the last pixel of the last line
    always_comb begin
        frame_wrap = tick && (qh_q == H_LAST) && (qv_q == V_LAST);
    end

    // One-cycle pulse aligned with the (0,0) counter update
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            fin_cuadro_q <= 1'b0;
        end else begin
            fin_cuadro_q <= frame_wrap;
        end
    end

    // Registered end-of-frame pulse onto its port
    always_comb begin
        fin_cuadro = fin_cuadro_q;
    end
`endif

    // Output drive
    always_comb begin
        Qh         = qh_q;
        Qv         = qv_q;
        pixel_tick = tick;
        hsync      = hsync_q;
        vsync      = vsync_q;
        video_on   = video_on_q;
    end

endmodule

// File: tb/tb_generador_sync_vga.sv
// Bench for generador_sync_vga: a default-timing instance (line-level and Qv carry checks)
// and a shrunken-timing instance (15x8 frame) for whole-frame behaviour.
module tb_generador_sync_vga;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [9:0] a_qh, a_qv, b_qh, b_qv;
    logic a_tick, a_hs, a_vs, a_vo;
    logic b_tick, b_hs, b_vs, b_vo;
`ifdef GENSYNC_FRAME_TICK_EN
    logic a_fin, b_fin;
`endif

    generador_sync_vga dut_a (
        .reloj      (clk),
        .resetM     (rst),
        .Qh         (a_qh),
        .Qv         (a_qv),
        .pixel_tick (a_tick),
        .hsync      (a_hs),
        .vsync      (a_vs),
        .video_on   (a_vo)
`ifdef GENSYNC_FRAME_TICK_EN
        ,
        .fin_cuadro (a_fin)
`endif
    );

    // Small frame: H 8/2/3/2 (total 15, hsync 10..12), V 4/1/2/1 (total 8, vsync 5..6)
    generador_sync_vga #(
        .DIV_PIXEL (4),
        .H_VIS     (8),
        .H_FP      (2),
        .H_SYNC    (3),
        .H_BP      (2),
        .V_VIS     (4),
        .V_FP      (1),
        .V_SYNC    (2),
        .V_BP      (1)
    ) dut_b (
        .reloj      (clk),
        .resetM     (rst),
        .Qh         (b_qh),
        .Qv         (b_qv),
        .pixel_tick (b_tick),
        .hsync      (b_hs),
        .vsync      (b_vs),
        .video_on   (b_vo)
`ifdef GENSYNC_FRAME_TICK_EN
        ,
        .fin_cuadro (b_fin)
`endif
    );

    typedef struct {
        int unsigned idx;
        int          qh;
        int          qv;
        bit          hs;
        bit          vs;
        bit          vo;
    } vec_t;

    vec_t qa[$];
    vec_t qb[$];
    vec_t va, vb;

    int errors = 0;
    int checks = 0;
    bit first_pass = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_a(input int idx, input int qh, input int qv,
                          input bit hs, input bit vs, input bit vo);
        qa.push_back('{idx: idx, qh: qh, qv: qv, hs: hs, vs: vs, vo: vo});
    endtask

    task automatic push_b(input int idx, input int qh, input int qv,
                          input bit hs, input bit vs, input bit vo);
        qb.push_back('{idx: idx, qh: qh, qv: qv, hs: hs, vs: vs, vo: vo});
    endtask

    // ---------------- monitor A (default timing) ----------------
    int unsigned td_a;
    int cyc_a, last_tick_a;
    logic [9:0] pqh_a, pqv_a;
    logic ptick_a;
    int bad_step_a = 0, bad_dec_a = 0, bad_vo_a = 0, bad_gap_a = 0, hs_low_line0 = 0;
    bit exp_hs_a, exp_vs_a, exp_vo_a;

    always @(negedge clk) begin
        if (rst) begin
            td_a = 0; cyc_a = 0; last_tick_a = 0;
            pqh_a = '0; pqv_a = '0; ptick_a = 1'b0;
        end else begin
            cyc_a++;
            if ((a_qh != pqh_a || a_qv != pqv_a) && !ptick_a) bad_step_a++;
            if (td_a > 0) begin
                exp_hs_a = !(a_qh >= 656 && a_qh <= 751);
                exp_vs_a = !(a_qv >= 490 && a_qv <= 491);
                exp_vo_a = (a_qh < 640) && (a_qv < 480);
                if (a_hs !== exp_hs_a || a_vs !== exp_vs_a || a_vo !== exp_vo_a) bad_dec_a++;
            end
            if (a_vo && (a_qh >= 640 || a_qv >= 480)) bad_vo_a++;
            if (first_pass && td_a < 800 && a_hs == 1'b0) hs_low_line0++;
            if (a_tick) begin
                if (td_a == 0) chk("a_first_tick_cycle", cyc_a, 4);
                else if (cyc_a - last_tick_a != 4) bad_gap_a++;
                last_tick_a = cyc_a;
                if (qa.size() > 0 && qa[0].idx == td_a) begin
                    va = qa.pop_front();
                    chk($sformatf("a_qh@tick%0d", td_a), int'(a_qh), va.qh);
                    chk($sformatf("a_qv@tick%0d", td_a), int'(a_qv), va.qv);
                    chk($sformatf("a_hsync@tick%0d", td_a), int'(a_hs), int'(va.hs));
                    chk($sformatf("a_vsync@tick%0d", td_a), int'(a_vs), int'(va.vs));
                    chk($sformatf("a_video_on@tick%0d", td_a), int'(a_vo), int'(va.vo));
                end
                td_a++;
            end
            pqh_a = a_qh; pqv_a = a_qv; ptick_a = a_tick;
        end
    end

    // ---------------- monitor B (small timing) ----------------
    int unsigned td_b;
    logic [9:0] pqh_b, pqv_b;
    logic ptick_b;
    int bad_step_b = 0, bad_dec_b = 0, bad_vo_b = 0, vs_low_f2 = 0, vo_ticks_f2 = 0;
    int bad_fin_b = 0, fin_at_120 = 0;
    bit exp_hs_b, exp_vs_b, exp_vo_b;

    always @(negedge clk) begin
        if (rst) begin
            td_b = 0; pqh_b = '0; pqv_b = '0; ptick_b = 1'b0;
        end else begin
            if ((b_qh != pqh_b || b_qv != pqv_b) && !ptick_b) bad_step_b++;
            if (td_b > 0) begin
                exp_hs_b = !(b_qh >= 10 && b_qh <= 12);
                exp_vs_b = !(b_qv >= 5 && b_qv <= 6);
                exp_vo_b = (b_qh < 8) && (b_qv < 4);
                if (b_hs !== exp_hs_b || b_vs !== exp_vs_b || b_vo !== exp_vo_b) bad_dec_b++;
            end
            if (b_vo && (b_qh >= 8 || b_qv >= 4)) bad_vo_b++;
            if (first_pass && td_b >= 120 && td_b < 240) begin
                if (b_vs == 1'b0) vs_low_f2++;
                if (b_tick && b_vo) vo_ticks_f2++;
            end
`ifdef GENSYNC_FRAME_TICK_EN
            if (b_fin !== (ptick_b && (td_b % 120 == 0))) bad_fin_b++;
            if (first_pass && td_b == 120 && b_fin) fin_at_120++;
`endif
            if (b_tick) begin
                if (qb.size() > 0 && qb[0].idx == td_b) begin
                    vb = qb.pop_front();
                    chk($sformatf("b_qh@tick%0d", td_b), int'(b_qh), vb.qh);
                    chk($sformatf("b_qv@tick%0d", td_b), int'(b_qv), vb.qv);
                    chk($sformatf("b_hsync@tick%0d", td_b), int'(b_hs), int'(vb.hs));
                    chk($sformatf("b_vsync@tick%0d", td_b), int'(b_vs), int'(vb.vs));
                    chk($sformatf("b_video_on@tick%0d", td_b), int'(b_vo), int'(vb.vo));
                end
                td_b++;
            end
            pqh_b = b_qh; pqv_b = b_qv; ptick_b = b_tick;
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_a_qh"}, int'(a_qh), 0);
        chk({tag, "_a_qv"}, int'(a_qv), 0);
        chk({tag, "_a_tick"}, int'(a_tick), 0);
        chk({tag, "_a_hsync"}, int'(a_hs), 1);
        chk({tag, "_a_vsync"}, int'(a_vs), 1);
        chk({tag, "_a_video_on"}, int'(a_vo), 0);
        chk({tag, "_b_qh"}, int'(b_qh), 0);
        chk({tag, "_b_qv"}, int'(b_qv), 0);
        chk({tag, "_b_tick"}, int'(b_tick), 0);
        chk({tag, "_b_video_on"}, int'(b_vo), 0);
`ifdef GENSYNC_FRAME_TICK_EN
        chk({tag, "_a_fin"}, int'(a_fin), 0);
        chk({tag, "_b_fin"}, int'(b_fin), 0);
`endif
    endtask

    // ---------------- stimulus ----------------
    int n;

    initial begin
        // Default timing: idx = ticks since release, Qh = idx%800, Qv = idx/800
        push_a(0,    0,   0,  1, 1, 0);
        push_a(1,    1,   0,  1, 1, 1);
        push_a(639,  639, 0,  1, 1, 1);
        push_a(640,  640, 0,  1, 1, 0);
        push_a(655,  655, 0,  1, 1, 0);
        push_a(656,  656, 0,  0, 1, 0);
        push_a(751,  751, 0,  0, 1, 0);
        push_a(752,  752, 0,  1, 1, 0);
        push_a(799,  799, 0,  1, 1, 0);
        push_a(800,  0,   1,  1, 1, 1);
        push_a(8799, 799, 10, 1, 1, 0);
        push_a(8800, 0,   11, 1, 1, 1);
        // Small timing: Qh = idx%15, Qv = (idx/15)%8
        push_b(0,   0,  0, 1, 1, 0);
        push_b(1,   1,  0, 1, 1, 1);
        push_b(10,  10, 0, 0, 1, 0);
        push_b(13,  13, 0, 1, 1, 0);
        push_b(75,  0,  5, 1, 0, 0);
        push_b(104, 14, 6, 1, 0, 0);
        push_b(105, 0,  7, 1, 1, 0);
        push_b(119, 14, 7, 1, 1, 0);
        push_b(120, 0,  0, 1, 1, 1);

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;

        // Run the default instance to Qh=300, Qv=11 (tick 9100)
        n = 0;
        while (!(a_qh == 300 && a_qv == 11) && n < 40000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_qh300_qv11", int'(n < 40000), 1);

        chk("hsync_low_clocks_line0", hs_low_line0, 384);
        chk("b_vsync_low_clocks_frame2", vs_low_f2, 120);
        chk("b_video_on_ticks_frame2", vo_ticks_f2, 32);
`ifdef GENSYNC_FRAME_TICK_EN
        chk("b_fin_pulse_at_wrap", fin_at_120, 1);
`endif
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);

        // Asynchronous reset mid-pixel, checked before the next clock edge
        @(posedge clk);
        #2;
        first_pass = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_values("midreset");

        push_a(0, 0, 0, 1, 1, 0);
        push_a(1, 1, 0, 1, 1, 1);
        push_a(2, 2, 0, 1, 1, 1);
        push_b(0, 0, 0, 1, 1, 0);
        push_b(1, 1, 0, 1, 1, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        n = 0;
        while ((qa.size() > 0 || qb.size() > 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("restart_vectors_drained", int'(qa.size() + qb.size()), 0);
        repeat (4) @(posedge clk);
        #1;

        chk("a_counter_step_outside_tick", bad_step_a, 0);
        chk("b_counter_step_outside_tick", bad_step_b, 0);
        chk("a_decode_mismatch_cycles", bad_dec_a, 0);
        chk("b_decode_mismatch_cycles", bad_dec_b, 0);
        chk("a_video_on_outside_visible", bad_vo_a, 0);
        chk("b_video_on_outside_visible", bad_vo_b, 0);
        chk("a_tick_spacing_errors", bad_gap_a, 0);
`ifdef GENSYNC_FRAME_TICK_EN
        chk("b_fin_mismatch_cycles", bad_fin_b, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
